aes_spi_responder: RTL and testbench

- SPI responder (slave end) for the AES core, driven by Spi_master.
- Receives one frame per transaction on mosi: 128-bit data block followed by an NK*32-bit key, MSB first.
- Presents the frame plus an encrypt/decrypt mode to the cipher datapath, then returns the 128-bit cipher result on miso during the next transaction.
- Runs entirely in the system clock domain; sclk, scs1, scs2 and mosi are oversampled.

---
 rtl/aes_spi_responder.sv | 206 ++++++++++++++++++++
 tb/tb_aes_spi_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : aes_spi_responder
// Description : SPI responder for the AES core. Oversamples sclk/scs1/scs2/mosi
//               in the system clock domain, collects one data+key frame per
//               transaction and returns the previously loaded cipher result
//               on miso, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_spi_responder #(
    parameter int NK          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                scs1,
    input  logic                scs2,
    input  logic                mosi,
    output logic                miso,
    output logic [127:0]        data_out,
    output logic [NK*32-1:0]    key_out,
    output logic                mode,
    output logic                frame_valid,
    output logic                frame_err,
    input  logic [127:0]        result_in,
    input  logic                result_valid,
    output logic                tx_loaded
);

    localparam int KEY_W   = NK * 32;
    localparam int FRAME_W = 128 + KEY_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Synchronizer chains; the last element is the synchronized value.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_scs1_sync;
    logic [SYNC_STAGES-1:0] r_scs2_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    // The final bit of a frame goes straight to the outputs, so the shift
    // register only needs to retain FRAME_W-1 bits between rises.
    logic [FRAME_W-2:0]     r_shift;
    logic [127:0]           r_data;
    logic [KEY_W-1:0]       r_key;
    logic                   r_mode;
    logic                   r_frame_valid;
    logic                   r_frame_err;
    logic [127:0]           r_tx;
    logic                   r_tx_loaded;
    logic                   r_miso;

    logic                   w_sclk_s;
    logic                   w_scs1_s;
    logic                   w_scs2_s;
    logic                   w_mosi_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cs_any;
    logic                   w_cs_both;
    logic [FRAME_W-1:0]     w_shift_next;
    logic [127:0]           w_tx_src;
    logic                   w_tx_avail;

    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_scs1_s     = r_scs1_sync[SYNC_STAGES-1];
    assign w_scs2_s     = r_scs2_sync[SYNC_STAGES-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise       = w_sclk_s & ~r_sclk_d;
    assign w_fall       = ~w_sclk_s & r_sclk_d;
    assign w_cs_any     = w_scs1_s | w_scs2_s;
    assign w_cs_both    = w_scs1_s & w_scs2_s;
    assign w_shift_next = {r_shift, w_mosi_s};

    // A result strobed in the same cycle a transaction starts is sent at once.
    assign w_tx_src     = result_valid ? result_in : r_tx;
    assign w_tx_avail   = r_tx_loaded | result_valid;

    assign miso         = r_miso;
    assign data_out     = r_data;
    assign key_out      = r_key;
    assign mode         = r_mode;
    assign frame_valid  = r_frame_valid;
    assign frame_err    = r_frame_err;
    assign tx_loaded    = r_tx_loaded;

    // Multi-stage synchronizers plus the delayed sclk used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_scs1_sync <= '0;
            r_scs2_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_scs1_sync <= {r_scs1_sync[SYNC_STAGES-2:0], scs1};
            r_scs2_sync <= {r_scs2_sync[SYNC_STAGES-2:0], scs2};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
        end
    end

    // Transaction FSM with receive shift path and transmit buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_key         <= '0;
            r_mode        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_tx          <= '0;
            r_tx_loaded   <= 1'b0;
            r_miso        <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;

            // Result loads are held off while a frame is being exchanged.
            if (result_valid && (r_state != ST_RX)) begin
                r_tx        <= result_in;
                r_tx_loaded <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_both) begin
                        r_state     <= ST_ERR;
                        r_frame_err <= 1'b1;
                    end else if (w_cs_any) begin
                        r_state     <= ST_RX;
                        r_mode      <= w_scs1_s;
                        r_cnt       <= '0;
                        r_tx_loaded <= 1'b0;
                        if (w_tx_avail) begin
                            r_tx   <= w_tx_src;
                            r_miso <= w_tx_src[127];
                        end else begin
                            r_tx   <= '0;
                            r_miso <= 1'b0;
                        end
                    end
                end

                ST_RX: begin
                    // Deselect or double select beats any edge in the same cycle.
                    if (w_cs_both) begin
                        r_state     <= ST_ERR;
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                    end else if (!w_cs_any) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                    end else begin
                        if (w_fall) begin
                            r_tx   <= {r_tx[126:0], 1'b0};
                            r_miso <= r_tx[126];
                        end
                        if (w_rise) begin
                            r_shift <= w_shift_next[FRAME_W-2:0];
                            if (r_cnt == CNT_W'(FRAME_W - 1)) begin
                                r_data        <= w_shift_next[FRAME_W-1 -: 128];
                                r_key         <= w_shift_next[KEY_W-1:0];
                                r_frame_valid <= 1'b1;
                                r_cnt         <= CNT_W'(FRAME_W);
                                r_state       <= ST_HOLD;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    if (!w_cs_any) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_ERR: begin
                    if (!w_cs_any) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_spi_responder
// Description : Self-checking bench for aes_spi_responder (NK=4). Acts as the
//               SPI master and compares against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_spi_responder;

    localparam int NK = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           sclk;
    logic           scs1;
    logic           scs2;
    logic           mosi;
    logic           miso;
    logic [127:0]   data_out;
    logic [127:0]   key_out;
    logic           mode;
    logic           frame_valid;
    logic           frame_err;
    logic [127:0]   result_in;
    logic           result_valid;
    logic           tx_loaded;

    aes_spi_responder #(.NK(NK), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .scs1         (scs1),
        .scs2         (scs2),
        .mosi         (mosi),
        .miso         (miso),
        .data_out     (data_out),
        .key_out      (key_out),
        .mode         (mode),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .result_in    (result_in),
        .result_valid (result_valid),
        .tx_loaded    (tx_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: frame under transmission and what the DUT holds.
    logic [255:0]   frame;
    logic [127:0]   exp_data   = '0;
    logic [127:0]   exp_key    = '0;
    logic [127:0]   exp_result = '0;
    bit             exp_loaded = 1'b0;

    // Pulse observers.
    int             fv_cnt = 0;
    int             fe_cnt = 0;
    logic [127:0]   cap_data;
    logic [127:0]   cap_key;
    logic           cap_mode;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt   = fv_cnt + 1;
            cap_data = data_out;
            cap_key  = key_out;
            cap_mode = mode;
        end
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    task automatic load_result(input logic [127:0] val);
        result_in    = val;
        result_valid = 1'b1;
        wait_clk(1);
        result_valid = 1'b0;
        exp_loaded   = 1'b1;
        exp_result   = val;
        wait_clk(1);
        check_eq("tx_loaded_after_load", tx_loaded, 1'b1);
    endtask

    // One master transaction. abort_kind: 1 = deselect at abort_at, 2 = reset at abort_at.
    task automatic xfer(input bit enc, input int nbits, input int abort_at,
                        input int abort_kind, input bit glitch);
        logic [127:0] mbits;
        logic [127:0] exp_m;
        int           late;
        int           fv0;
        int           fe0;
        bit           aborted;
        mbits   = '0;
        late    = 0;
        aborted = 1'b0;
        fv0     = fv_cnt;
        fe0     = fe_cnt;
        exp_m   = exp_loaded ? exp_result : '0;
        exp_loaded = 1'b0;

        scs1 = enc;
        scs2 = ~enc;
        wait_clk(6);
        check_eq("tx_loaded_start", tx_loaded, 1'b0);

        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            mosi = (i < 256) ? frame[255 - i] : 1'($urandom);
            if (glitch && i == 50) begin
                wait_clk(2);
                result_in    = rand128();
                result_valid = 1'b1;
                wait_clk(1);
                result_valid = 1'b0;
                wait_clk(2);
            end else begin
                wait_clk(5);
            end
            if (i < 128) mbits[127 - i] = miso;
            else if (miso !== 1'b0) late++;
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end

        if (aborted && abort_kind == 2) begin
            rst  = 1'b1;
            scs1 = 1'b0;
            scs2 = 1'b0;
            mosi = 1'b0;
            wait_clk(1);
            check_eq("rst_data_out", data_out, '0);
            check_eq("rst_key_out", key_out, '0);
            check_eq("rst_mode", mode, 1'b0);
            check_eq("rst_miso", miso, 1'b0);
            check_eq("rst_tx_loaded", tx_loaded, 1'b0);
            check_eq("rst_pulses", {frame_valid, frame_err}, 2'b00);
            rst     = 1'b0;
            exp_data = '0;
            exp_key  = '0;
        end else if (!aborted) begin
            wait_clk(5);
        end
        scs1 = 1'b0;
        scs2 = 1'b0;
        mosi = 1'b0;
        wait_clk(8);

        if (!aborted) begin
            check_eq("fv_count", 32'(fv_cnt - fv0), 32'd1);
            check_eq("fe_count", 32'(fe_cnt - fe0), 32'd0);
            check_eq("cap_data", cap_data, frame[255:128]);
            check_eq("cap_key", cap_key, frame[127:0]);
            check_eq("cap_mode", cap_mode, enc);
            check_eq("data_out_hold", data_out, frame[255:128]);
            check_eq("miso_bits", mbits, exp_m);
            if (nbits > 128) check_eq("miso_after_128", 32'(late), 32'd0);
            exp_data = frame[255:128];
            exp_key  = frame[127:0];
        end else if (abort_kind == 1) begin
            check_eq("abort_fe_count", 32'(fe_cnt - fe0), 32'd1);
            check_eq("abort_fv_count", 32'(fv_cnt - fv0), 32'd0);
            check_eq("abort_data_kept", data_out, exp_data);
            check_eq("abort_key_kept", key_out, exp_key);
        end else begin
            check_eq("rst_fe_count", 32'(fe_cnt - fe0), 32'd0);
            check_eq("rst_fv_count", 32'(fv_cnt - fv0), 32'd0);
        end
        if (glitch) check_eq("tx_loaded_ignored_in_rx", tx_loaded, 1'b0);
    endtask

    task automatic both_high();
        int fv0;
        int fe0;
        fv0  = fv_cnt;
        fe0  = fe_cnt;
        scs1 = 1'b1;
        scs2 = 1'b1;
        wait_clk(6);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'($urandom);
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        scs1 = 1'b0;
        scs2 = 1'b0;
        wait_clk(8);
        check_eq("both_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check_eq("both_fv_count", 32'(fv_cnt - fv0), 32'd0);
        check_eq("both_data_kept", data_out, exp_data);
    endtask

    initial begin
        rst          = 1'b1;
        sclk         = 1'b0;
        scs1         = 1'b0;
        scs2         = 1'b0;
        mosi         = 1'b0;
        result_in    = '0;
        result_valid = 1'b0;
        wait_clk(3);
        check_eq("reset_data_out", data_out, '0);
        check_eq("reset_key_out", key_out, '0);
        check_eq("reset_mode", mode, 1'b0);
        check_eq("reset_miso", miso, 1'b0);
        check_eq("reset_tx_loaded", tx_loaded, 1'b0);
        check_eq("reset_pulses", {frame_valid, frame_err}, 2'b00);
        rst = 1'b0;
        wait_clk(2);

        // Known-answer encrypt frame.
        frame = {128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
        xfer(1'b1, 256, -1, 0, 1'b0);

        // Decrypt frame while returning a loaded result.
        load_result(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        frame = {128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f};
        xfer(1'b0, 256, -1, 0, 1'b0);

        // Deselect after 100 bits, then a clean frame.
        frame = rand256();
        xfer(1'b1, 256, 100, 1, 1'b0);
        frame = rand256();
        xfer(1'($urandom), 256, -1, 0, 1'b0);

        // Both selects high, then an over-long frame.
        both_high();
        frame = rand256();
        xfer(1'b1, 300, -1, 0, 1'b0);

        // Reset in the middle of a frame, then a clean frame with a result.
        frame = rand256();
        xfer(1'b1, 256, 60, 2, 1'b0);
        load_result(rand128());
        frame = rand256();
        xfer(1'b0, 256, -1, 0, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 5; t++) begin
            if ($urandom_range(0, 1) == 1) load_result(rand128());
            frame = rand256();
            xfer(1'($urandom), 256, -1, 0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
